// File: rtl/fifo_sync_ram_param.sv
// Single-clock RAM FIFO of any depth >= 2, with fill level, thresholds, flush and sticky errors.
// Read latency is 1 cycle (FWFT=0) or head-visible (FWFT=1); status flags follow an accept by 1 cycle.
// Writes are refused when FULL and reads when EMPTY; each refused request sets a sticky error flag.
module fifo_sync_ram_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 200,
    parameter int AF_THRESH  = 190,
    parameter int AE_THRESH  = 8,
    parameter int FWFT       = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         FLUSH,
    input  logic                         CLR_ERR,
    input  logic                         W_EN,
    input  logic [DATA_WIDTH-1:0]        W_Data,
    input  logic                         R_EN,
    output logic [DATA_WIDTH-1:0]        R_Data,
    output logic                         R_Valid,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic                         ALMOST_FULL,
    output logic                         ALMOST_EMPTY,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  unf_set;

    assign FULL         = (level_q == LW'(DEPTH));
    assign EMPTY        = (level_q == '0);
    assign ALMOST_FULL  = (level_q >= LW'(AF_THRESH));
    assign ALMOST_EMPTY = (level_q <= LW'(AE_THRESH));
    assign LEVEL        = level_q;

    // Accepts look only at registered state, so a full FIFO never takes a write even while draining.
    assign wr_acc  = W_EN & ~FULL  & ~FLUSH;
    assign rd_acc  = R_EN & ~EMPTY & ~FLUSH;
    assign ovf_set = W_EN & FULL   & ~FLUSH;
    assign unf_set = R_EN & EMPTY  & ~FLUSH;

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= W_Data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            OVERFLOW  <= ovf_set | (OVERFLOW  & ~CLR_ERR);
            UNDERFLOW <= unf_set | (UNDERFLOW & ~CLR_ERR);
            if (FLUSH) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
                end
                case ({wr_acc, rd_acc})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero while empty to match the reset value.
            assign R_Data  = EMPTY ? '0 : mem[rd_ptr];
            assign R_Valid = ~EMPTY;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_data_q;
            logic                  r_valid_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_acc;
                    if (rd_acc) begin
                        r_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign R_Data  = r_data_q;
            assign R_Valid = r_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_ram_param.sv
// Drives a registered-read and a first-word-fall-through FIFO with identical stimulus and checks
// both against a queue-based reference model after every clock.
module tb_fifo_sync_ram_param;

    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST;
    logic          FLUSH;
    logic          CLR_ERR;
    logic          W_EN;
    logic [7:0]    W_Data;
    logic          R_EN;

    logic [7:0]    r_data_a,  r_data_b;
    logic          r_valid_a, r_valid_b;
    logic          full_a,    full_b;
    logic          empty_a,   empty_b;
    logic          af_a,      af_b;
    logic          ae_a,      ae_b;
    logic [LW-1:0] level_a,   level_b;
    logic          ovf_a,     ovf_b;
    logic          unf_a,     unf_b;

    fifo_sync_ram_param #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) u_reg (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
        .W_EN(W_EN), .W_Data(W_Data), .R_EN(R_EN),
        .R_Data(r_data_a), .R_Valid(r_valid_a), .FULL(full_a), .EMPTY(empty_a),
        .ALMOST_FULL(af_a), .ALMOST_EMPTY(ae_a), .LEVEL(level_a),
        .OVERFLOW(ovf_a), .UNDERFLOW(unf_a)
    );

    fifo_sync_ram_param #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) u_fwft (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
        .W_EN(W_EN), .W_Data(W_Data), .R_EN(R_EN),
        .R_Data(r_data_b), .R_Valid(r_valid_b), .FULL(full_b), .EMPTY(empty_b),
        .ALMOST_FULL(af_b), .ALMOST_EMPTY(ae_b), .LEVEL(level_b),
        .OVERFLOW(ovf_b), .UNDERFLOW(unf_b)
    );

    always #5 CLK = ~CLK;

    // Reference model: contents as a queue, plus the registered-read output word and sticky errors.
    logic [7:0] q[$];
    logic [7:0] m_rdata;
    logic       m_rvalid;
    logic       m_ovf;
    logic       m_unf;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("level_reg",  32'(level_a),   32'(n));
        chk("level_fwft", 32'(level_b),   32'(n));
        chk("full_reg",   32'(full_a),    32'(n == DEPTH));
        chk("full_fwft",  32'(full_b),    32'(n == DEPTH));
        chk("empty_reg",  32'(empty_a),   32'(n == 0));
        chk("empty_fwft", 32'(empty_b),   32'(n == 0));
        chk("afull_reg",  32'(af_a),      32'(n >= AF));
        chk("afull_fwft", 32'(af_b),      32'(n >= AF));
        chk("aempty_reg", 32'(ae_a),      32'(n <= AE));
        chk("aempty_fwft",32'(ae_b),      32'(n <= AE));
        chk("ovf_reg",    32'(ovf_a),     32'(m_ovf));
        chk("ovf_fwft",   32'(ovf_b),     32'(m_ovf));
        chk("unf_reg",    32'(unf_a),     32'(m_unf));
        chk("unf_fwft",   32'(unf_b),     32'(m_unf));
        chk("rvalid_reg", 32'(r_valid_a), 32'(m_rvalid));
        chk("rdata_reg",  32'(r_data_a),  32'(m_rdata));
        chk("rvalid_fwft",32'(r_valid_b), 32'(n != 0));
        chk("rdata_fwft", 32'(r_data_b),  (n != 0) ? 32'(q[0]) : 32'h0);
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata  = 8'h00;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic fl, input logic clr);
        logic was_full;
        logic was_empty;
        W_EN = w; W_Data = d; R_EN = r; FLUSH = fl; CLR_ERR = clr;
        @(posedge CLK);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_ovf = (w & was_full  & ~fl) | (m_ovf & ~clr);
        m_unf = (r & was_empty & ~fl) | (m_unf & ~clr);
        m_rvalid = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (r && !was_empty) begin
                m_rdata  = q.pop_front();
                m_rvalid = 1'b1;
            end
            if (w && !was_full) q.push_back(d);
        end
        @(negedge CLK);
        W_EN = 1'b0; R_EN = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic [7:0] d); step(1'b1, d,     1'b0, 1'b0, 1'b0); endtask
    task automatic rd();                    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask
    task automatic both(input logic [7:0] d); step(1'b1, d,   1'b1, 1'b0, 1'b0); endtask
    task automatic clr();                   step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); endtask
    task automatic idle();                  step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; CLR_ERR = 1'b0; W_EN = 1'b0; R_EN = 1'b0; W_Data = 8'h00;
        model_reset();
        repeat (2) @(negedge CLK);
        check_all();
        RST = 1'b0;
        idle();

        // Fill to full, overflow attempt, then drain in order.
        for (int i = 0; i < 5; i++) wr(8'h11 + 8'(i));
        wr(8'h16);
        clr();
        for (int i = 0; i < 5; i++) rd();
        idle();

        // Repeated 3-in/3-out bursts force both pointers through the 4->0 wrap.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) wr(8'(8'h40 + k * 3 + i));
            for (int i = 0; i < 3; i++) rd();
        end

        // Simultaneous read/write at mid level, full and empty.
        wr(8'h21); wr(8'h22);
        both(8'h23);
        wr(8'h24); wr(8'h25); wr(8'h26);
        both(8'h27);
        clr();
        for (int i = 0; i < 4; i++) rd();
        both(8'h28);
        clr();
        rd();

        // Single word through the fall-through path.
        wr(8'hA5);
        idle();
        rd();
        idle();

        // Flush at level 3 with a concurrent write request.
        wr(8'h31); wr(8'h32); wr(8'h33);
        step(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
        idle();

        // Asynchronous reset in the middle of a burst.
        wr(8'h51); wr(8'h52); rd(); wr(8'h53);
        #2 RST = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b0;
        idle();

        // Randomised traffic with write/read bias phases so full and empty are both visited.
        for (int i = 0; i < 800; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            step(1'($urandom_range(0, 99) < wp),
                 8'($urandom),
                 1'($urandom_range(0, 99) < (100 - wp)),
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
